// File: rtl/popcount_sched_pkg.sv
// Shared bitboard constants and the popcount-core latency used by popcount_sched.
// Also holds the word-count correction applied to the core's 6-bit result.
package popcount_sched_pkg;

  localparam int unsigned BB_W        = 64;
  localparam int unsigned PC_CORE_LAT = 5;
  localparam int unsigned PC_W        = 6;
  localparam logic [BB_W-1:0] BB_FULL = 64'hFFFF_FFFF_FFFF_FFFF;

  // The core wraps 64 to 0; a full board is flagged at issue and restored here.
  function automatic logic [6:0] word_count(input logic full, input logic [PC_W-1:0] core);
    return full ? 7'd64 : {1'b0, core};
  endfunction

endpackage

// File: rtl/popcount_core.sv
// Shared popcount core: fixed-latency pipeline, no valid, no reset, 6-bit wrapping count.
module popcount_core #(
  parameter int unsigned LAT = 5
) (
  input  logic        clk,
  input  logic [63:0] data_i,
  output logic [5:0]  count_o
);

  logic [5:0] cnt;
  logic [5:0] pipe_q [LAT];

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < 64; i++) cnt = cnt + 6'(data_i[i]);
  end

  always_ff @(posedge clk) begin
    pipe_q[0] <= cnt;
    for (int unsigned i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign count_o = pipe_q[LAT-1];

endmodule

// File: rtl/popcount_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a pointer that moves past each winner.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic          found;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr_q) + k) % N);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        ptr_d        = PW'((32'(idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/popcount_sched.sv
// Shares one popcount core among NREQ requesters; sums each job's words per requester
// and returns one saturating result per job on a shared response bus.
module popcount_sched
  import popcount_sched_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned CORE_LAT = PC_CORE_LAT,
  parameter int unsigned CW       = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [BB_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [CW-1:0]        resp_count,
  output logic                 resp_sat,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(NREQ);
  localparam int unsigned SW = CW + 1;

  logic [NREQ-1:0] grant;
  logic            fire, sel_last;
  logic [TW-1:0]   sel_tag;
  logic [BB_W-1:0] sel_data;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk    (clk),
    .rst_n  (reset),
    .req_i  (req_valid),
    .grant_o(grant)
  );

  assign req_ready = grant;
  assign fire      = |grant;

  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_tag  = TW'(i);
        sel_data = req_data[i*BB_W +: BB_W];
        sel_last = req_last[i];
      end
    end
  end

  logic            iss_v_q, iss_last_q, iss_full_q;
  logic [TW-1:0]   iss_tag_q;
  logic [BB_W-1:0] iss_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss_v_q    <= 1'b0;
      iss_tag_q  <= '0;
      iss_last_q <= 1'b0;
      iss_full_q <= 1'b0;
    end else begin
      iss_v_q <= fire;
      if (fire) begin
        iss_tag_q  <= sel_tag;
        iss_last_q <= sel_last;
        iss_full_q <= (sel_data == BB_FULL);
      end
    end
  end

  // Data path needs no reset: stale core output is masked by the shadow valids.
  always_ff @(posedge clk) begin
    if (fire) iss_data_q <= sel_data;
  end

  logic [PC_W-1:0] core_cnt;

  popcount_core #(.LAT(CORE_LAT)) u_core (
    .clk    (clk),
    .data_i (iss_data_q),
    .count_o(core_cnt)
  );

  logic [CORE_LAT-1:0] sh_v_q, sh_last_q, sh_full_q;
  logic [TW-1:0]       sh_tag_q [CORE_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_v_q    <= '0;
      sh_last_q <= '0;
      sh_full_q <= '0;
      for (int unsigned i = 0; i < CORE_LAT; i++) sh_tag_q[i] <= '0;
    end else begin
      sh_v_q[0]    <= iss_v_q;
      sh_last_q[0] <= iss_last_q;
      sh_full_q[0] <= iss_full_q;
      sh_tag_q[0]  <= iss_tag_q;
      for (int unsigned i = 1; i < CORE_LAT; i++) begin
        sh_v_q[i]    <= sh_v_q[i-1];
        sh_last_q[i] <= sh_last_q[i-1];
        sh_full_q[i] <= sh_full_q[i-1];
        sh_tag_q[i]  <= sh_tag_q[i-1];
      end
    end
  end

  logic          al_v, al_last;
  logic [TW-1:0] al_tag;
  logic [6:0]    wc;
  logic [SW-1:0] sum;
  logic [CW-1:0] acc_new;
  logic          sat_new;

  logic [CW-1:0]   acc_q [NREQ];
  logic [NREQ-1:0] sat_q, open_q, resp_valid_q;
  logic [CW-1:0]   resp_count_q;
  logic            resp_sat_q;

  assign al_v    = sh_v_q[CORE_LAT-1];
  assign al_last = sh_last_q[CORE_LAT-1];
  assign al_tag  = sh_tag_q[CORE_LAT-1];

  always_comb begin
    wc      = word_count(sh_full_q[CORE_LAT-1], core_cnt);
    sum     = {1'b0, acc_q[al_tag]} + SW'(wc);
    acc_new = sum[CW] ? '1 : sum[CW-1:0];
    sat_new = sat_q[al_tag] | sum[CW];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREQ; i++) acc_q[i] <= '0;
      sat_q        <= '0;
      open_q       <= '0;
      resp_valid_q <= '0;
      resp_count_q <= '0;
      resp_sat_q   <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      if (al_v) begin
        if (al_last) begin
          resp_valid_q[al_tag] <= 1'b1;
          resp_count_q         <= acc_new;
          resp_sat_q           <= sat_new;
          acc_q[al_tag]        <= '0;
          sat_q[al_tag]        <= 1'b0;
          open_q[al_tag]       <= 1'b0;
        end else begin
          acc_q[al_tag]  <= acc_new;
          sat_q[al_tag]  <= sat_new;
          open_q[al_tag] <= 1'b1;
        end
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_count = resp_count_q;
  assign resp_sat   = resp_sat_q;
  assign busy       = (|sh_v_q) | iss_v_q | (|open_q);

endmodule

// File: tb/tb_popcount_sched.sv
// Randomized bench for popcount_sched: a job-level scoreboard predicts each response
// (requester, clamped population, saturation flag, arrival cycle) from accepted words.
module tb_popcount_sched;

  localparam int NREQ = 4;
  localparam int CW   = 11;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic [7:0]  tag;
    logic [15:0] count;
    logic        sat;
    logic [31:0] cyc;
  } resp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid, req_last, req_ready, resp_valid;
  logic [64*NREQ-1:0]   req_data;
  logic [CW-1:0]        resp_count;
  logic                 resp_sat, busy;

  logic        tb_v [NREQ];
  logic        tb_l [NREQ];
  logic [63:0] tb_d [NREQ];

  int vectors     = 0;
  int miscompares = 0;

  resp_t       exp_q[$];
  resp_t       obs_q[$];
  int unsigned cyc = 0;
  int          model_acc [NREQ];
  int          ptr_model = 0;

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = tb_v[i];
      req_last[i]           = tb_l[i];
      req_data[64*i +: 64]  = tb_d[i];
    end
  end

  popcount_sched #(.NREQ(NREQ), .CORE_LAT(5), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_count(resp_count),
    .resp_sat  (resp_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a word accepted at the coming edge (cyc+1) of a job whose total is T
  // yields a response visible after edge cyc+7 with count min(T, MAXC) and sat = T > MAXC.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      for (int i = 0; i < NREQ; i++) model_acc[i] = 0;
      ptr_model = 0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          model_acc[i] += $countones(req_data[64*i +: 64]);
          ptr_model = (i + 1) % NREQ;
          if (req_last[i]) begin
            exp_q.push_back('{tag: 8'(i),
                              count: 16'((model_acc[i] > MAXC) ? MAXC : model_acc[i]),
                              sat: (model_acc[i] > MAXC),
                              cyc: 32'(cyc + 7)});
            model_acc[i] = 0;
          end
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (resp_valid[i])
          obs_q.push_back('{tag: 8'(i), count: 16'(resp_count), sat: resp_sat, cyc: 32'(cyc)});
    end
  end

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    case ($urandom_range(3))
      0:       w = '1;
      1:       w = '0;
      2:       ;
      default: w = w & {$urandom, $urandom};
    endcase
    return w;
  endfunction

  // Offers one word and returns just after the edge it was accepted on.
  task automatic send_word(input int r, input logic [63:0] w, input logic last,
                           input int drop_pct, output bit ok);
    int t = 0;
    ok = 1'b0;
    tb_d[r] = w;
    tb_l[r] = last;
    tb_v[r] = 1'b1;
    while (t < 300) begin
      @(negedge clk);
      if (req_ready[r]) begin
        @(posedge clk); #1;
        tb_v[r] = 1'b0;
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
      t++;
      if (drop_pct > 0 && $urandom_range(99) < drop_pct) begin
        tb_v[r] = 1'b0;
        @(posedge clk); #1;
        tb_v[r] = 1'b1;
      end
    end
    tb_v[r] = 1'b0;
  endtask

  task automatic settle(output bit ok);
    int t = 0;
    @(posedge clk); #1;
    while (busy !== 1'b0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) begin @(posedge clk); #1; end
    ok = (t < 500);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (req_ready !== '0) begin $display("FAIL reset_ready: got %b want 0", req_ready); miscompares++; end
    vectors++;
    if (resp_valid !== '0) begin $display("FAIL reset_resp_valid: got %b want 0", resp_valid); miscompares++; end
    vectors++;
    if (resp_count !== '0) begin $display("FAIL reset_resp_count: got %0d want 0", resp_count); miscompares++; end
    vectors++;
    if (resp_sat !== 1'b0) begin $display("FAIL reset_resp_sat: got %b want 0", resp_sat); miscompares++; end
    vectors++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); miscompares++; end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      $display("FAIL idle_after_reset: busy=%b ready=%b want 0/0", busy, req_ready); miscompares++;
    end
  endtask

  task automatic test_single_word();
    bit ok, ok2;
    send_word(0, 64'h00FF_0000_0000_0001, 1'b1, 0, ok);
    settle(ok2);
    vectors++;
    if (!(ok && ok2) || obs_q.size() != 1 || exp_q.size() != 1) begin
      $display("FAIL single_word_count: got %0d responses want 1 (handshake/settle ok=%0d)",
               obs_q.size(), ok && ok2);
      miscompares++;
    end else begin
      vectors++;
      if (obs_q[0] !== exp_q[0]) begin
        $display("FAIL single_word_model: got tag=%0d cnt=%0d sat=%0d cyc=%0d want tag=%0d cnt=%0d sat=%0d cyc=%0d",
                 obs_q[0].tag, obs_q[0].count, obs_q[0].sat, obs_q[0].cyc,
                 exp_q[0].tag, exp_q[0].count, exp_q[0].sat, exp_q[0].cyc);
        miscompares++;
      end
      vectors++;
      if (obs_q[0].tag !== 8'd0 || obs_q[0].count !== 16'd9 || obs_q[0].sat !== 1'b0) begin
        $display("FAIL single_word_value: got tag=%0d cnt=%0d sat=%0d want 0/9/0",
                 obs_q[0].tag, obs_q[0].count, obs_q[0].sat);
        miscompares++;
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_all_ones();
    bit ok, ok2;
    send_word(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, ok);
    settle(ok2);
    vectors++;
    if (!(ok && ok2) || obs_q.size() != 1) begin
      $display("FAIL all_ones_count: got %0d responses want 1", obs_q.size()); miscompares++;
    end else begin
      vectors++;
      if (obs_q[0].tag !== 8'd1 || obs_q[0].count !== 16'd64 || obs_q[0].sat !== 1'b0 ||
          obs_q[0].cyc !== exp_q[0].cyc) begin
        $display("FAIL all_ones_value: got tag=%0d cnt=%0d sat=%0d cyc=%0d want 1/64/0 cyc=%0d",
                 obs_q[0].tag, obs_q[0].count, obs_q[0].sat, obs_q[0].cyc, exp_q[0].cyc);
        miscompares++;
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_multi_word();
    bit ok, ok2, okall;
    logic [63:0] words [4];
    words[0] = 64'h0000_0000_0000_00FF;
    words[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    words[2] = 64'h0;
    words[3] = 64'h8000_0000_0000_0000;
    okall = 1'b1;
    for (int j = 0; j < 4; j++) begin
      send_word(2, words[j], (j == 3), 0, ok);
      okall &= ok;
    end
    settle(ok2);
    vectors++;
    if (!(okall && ok2) || obs_q.size() != 1) begin
      $display("FAIL multi_word_count: got %0d responses want 1", obs_q.size()); miscompares++;
    end else begin
      vectors++;
      if (obs_q[0] !== exp_q[0] || obs_q[0].count !== 16'd73 || obs_q[0].tag !== 8'd2) begin
        $display("FAIL multi_word_value: got tag=%0d cnt=%0d sat=%0d cyc=%0d want 2/73/0 cyc=%0d",
                 obs_q[0].tag, obs_q[0].count, obs_q[0].sat, obs_q[0].cyc, exp_q[0].cyc);
        miscompares++;
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_contention();
    int  exp_g, drv_fail;
    bit  ok2;
    exp_g    = ptr_model;
    drv_fail = 0;
    for (int r = 0; r < NREQ; r++) begin
      fork
        automatic int rr = r;
        begin
          bit okw;
          for (int j = 0; j < 8; j++) begin
            send_word(rr, rand_word(), 1'b1, 0, okw);
            if (!okw) drv_fail++;
          end
        end
      join_none
    end
    for (int k = 0; k < 8 * NREQ - NREQ; k++) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== NREQ'(1 << exp_g)) begin
        $display("FAIL contention_grant: cycle %0d got %b want %b", k, req_ready, NREQ'(1 << exp_g));
        miscompares++;
      end
      exp_g = (exp_g + 1) % NREQ;
    end
    wait fork;
    settle(ok2);
    vectors++;
    if (drv_fail != 0 || !ok2 || obs_q.size() != exp_q.size() || obs_q.size() != 8 * NREQ) begin
      $display("FAIL contention_responses: got %0d want %0d (driver timeouts %0d)",
               obs_q.size(), 8 * NREQ, drv_fail);
      miscompares++;
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      resp_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        $display("FAIL contention_resp: got tag=%0d cnt=%0d sat=%0d cyc=%0d want tag=%0d cnt=%0d sat=%0d cyc=%0d",
                 o.tag, o.count, o.sat, o.cyc, e.tag, e.count, e.sat, e.cyc);
        miscompares++;
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_saturation();
    bit ok, ok2, okall;
    okall = 1'b1;
    for (int j = 0; j < 41; j++) begin
      send_word(3, 64'hFFFF_FFFF_FFFF_FFFF, (j == 40), 0, ok);
      okall &= ok;
    end
    send_word(3, 64'h3, 1'b1, 0, ok);
    okall &= ok;
    settle(ok2);
    vectors++;
    if (!(okall && ok2) || obs_q.size() != 2 || exp_q.size() != 2) begin
      $display("FAIL saturation_count: got %0d responses want 2", obs_q.size()); miscompares++;
    end else begin
      vectors++;
      if (obs_q[0] !== exp_q[0] || obs_q[0].count !== 16'(MAXC) || obs_q[0].sat !== 1'b1) begin
        $display("FAIL saturation_clamp: got cnt=%0d sat=%0d cyc=%0d want %0d/1 cyc=%0d",
                 obs_q[0].count, obs_q[0].sat, obs_q[0].cyc, MAXC, exp_q[0].cyc);
        miscompares++;
      end
      vectors++;
      if (obs_q[1] !== exp_q[1] || obs_q[1].count !== 16'd2 || obs_q[1].sat !== 1'b0) begin
        $display("FAIL saturation_next_job: got cnt=%0d sat=%0d want 2/0",
                 obs_q[1].count, obs_q[1].sat);
        miscompares++;
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    int drv_fail;
    bit ok2;
    drv_fail = 0;
    for (int r = 0; r < NREQ; r++) begin
      fork
        automatic int rr = r;
        begin
          bit okw;
          int len;
          for (int j = 0; j < 5; j++) begin
            len = $urandom_range(1, 5);
            for (int w = 0; w < len; w++) begin
              send_word(rr, rand_word(), (w == len - 1), 25, okw);
              if (!okw) drv_fail++;
              repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
          end
        end
      join_none
    end
    wait fork;
    settle(ok2);
    vectors++;
    if (drv_fail != 0 || !ok2 || obs_q.size() != exp_q.size()) begin
      $display("FAIL random_responses: got %0d want %0d (driver timeouts %0d)",
               obs_q.size(), exp_q.size(), drv_fail);
      miscompares++;
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      resp_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vectors++;
      if (o !== e) begin
        $display("FAIL random_resp: got tag=%0d cnt=%0d sat=%0d cyc=%0d want tag=%0d cnt=%0d sat=%0d cyc=%0d",
                 o.tag, o.count, o.sat, o.cyc, e.tag, e.count, e.sat, e.cyc);
        miscompares++;
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_job();
    bit ok, ok2, okall;
    okall = 1'b1;
    send_word(1, 64'hF0F0_F0F0_0000_0000, 1'b0, 0, ok); okall &= ok;
    send_word(0, 64'h7, 1'b1, 0, ok);                   okall &= ok;
    send_word(2, 64'hFFFF, 1'b1, 0, ok);                okall &= ok;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    vectors++;
    if (busy !== 1'b0) begin $display("FAIL reset_mid_busy: got %b want 0", busy); miscompares++; end
    repeat (12) @(posedge clk);
    #1;
    vectors++;
    if (!okall || obs_q.size() != 0) begin
      $display("FAIL reset_mid_no_resp: got %0d responses want 0", obs_q.size()); miscompares++;
    end
    obs_q.delete();
    send_word(0, 64'h3, 1'b1, 0, ok);
    settle(ok2);
    vectors++;
    if (!(ok && ok2) || obs_q.size() != 1 || exp_q.size() != 1) begin
      $display("FAIL reset_mid_new_job_count: got %0d responses want 1", obs_q.size()); miscompares++;
    end else begin
      vectors++;
      if (obs_q[0] !== exp_q[0] || obs_q[0].count !== 16'd2 || obs_q[0].sat !== 1'b0) begin
        $display("FAIL reset_mid_new_job: got tag=%0d cnt=%0d sat=%0d want 0/2/0",
                 obs_q[0].tag, obs_q[0].count, obs_q[0].sat);
        miscompares++;
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      tb_v[i] = 1'b0;
      tb_l[i] = 1'b0;
      tb_d[i] = '0;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single_word();
    test_all_ones();
    test_multi_word();
    test_contention();
    test_saturation();
    test_random();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/popcount_sched.md
Name: popcount_sched

Overview:
- Shares one popcount core (fixed 5-cycle latency, no valid, no reset) among NREQ requesters, e.g. move generator, evaluator mobility terms and king-safety scoring.
- Each requester streams jobs of one or more 64-bit bitboards; the block returns the total population of each job.
- Arbitration is round-robin at one word per cycle. A shadow valid/tag pipeline tracks in-flight words.
- The block also corrects the core's 6-bit wrap for an all-ones word, so a full board counts as 64.

Parameters:
- NREQ, 4, number of requesters (2..8)
- CORE_LAT, 5, popcount core latency in clocks (shadow pipeline depth)
- CW, 11, result width; covers up to 16 words × 64 with 1 bit of headroom

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- req_valid  in  NREQ  word offered by requester i
- req_data  in  64*NREQ  bitboard, slice i = bits [64i+63:64i]
- req_last  in  NREQ  offered word is final word of job
- req_ready  out  NREQ  one-hot grant; word transfers on valid&ready
- resp_valid  out  NREQ  one-cycle pulse, job result for requester i
- resp_count  out  CW  job population (shared bus, qualified by resp_valid)
- resp_sat  out  1  job accumulator saturated (qualified by resp_valid)
- busy  out  1  any word in flight or any accumulator non-zero/open

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_count=0, resp_sat=0, busy=0, rr pointer=0. All shadow valids=0, accumulators=0, open flags=0.
- Arbitration:
  - Combinational round-robin among req_valid, starting search at pointer.
  - req_ready is one-hot, or zero when no request is present.
  - After a grant to i, the pointer becomes (i+1) mod NREQ. With no grant, the pointer holds.
  - Requester must hold data/last stable while valid && !ready. Dropping valid before ready is legal; no word is lost or duplicated.
- Issue register (edge E0 = handshake edge) captures:
  - data;
  - tag = requester index;
  - last;
  - full = (data == all ones);
  - valid.
  Register data drives the core input every cycle; garbage is harmless because the shadow valid is 0.
- Shadow pipeline: CORE_LAT stages of {valid, tag, last, full}, reset to 0 asynchronously. It aligns with the core output, which is valid after E0+5.
- Word count: wc = full ? 64 : {1'b0, core_out}. This is a 7-bit correction of the core's 6-bit wrap.
- Accumulate at edge E0+6 when the aligned shadow valid is set:
  - Non-last word: acc[tag] <= sat_add(acc[tag], wc).
  - Last word: resp_valid[tag] <= 1, resp_count <= sat_add(acc[tag], wc), resp_sat <= sat flag, acc[tag] <= 0, sat[tag] <= 0.
  - sat_add clamps at 2^CW−1 and sets a sticky sat[tag].
- Latency: a single-word job handshaked at edge E0 gives resp_valid high in the cycle following edge E0+6.
- Throughput: one word per clock aggregate. Responses return in issue order. At most one response per cycle, so there is no response-bus conflict.
- Back-to-back jobs from the same requester are legal. The next job's first result arrives at least one cycle after the previous last result clears acc.
- Empty jobs are not possible; every job has at least one word.
- No response backpressure: requesters must accept resp_valid pulses.
- busy = any shadow valid | issue valid | any open job. A job is open after its first non-last word and until its last word returns.
- Reset mid-operation: all in-flight words and partial accumulations are discarded and no response is emitted. The core's stale output is ignored because the shadow valids are cleared.

Decomposition:
- Shared package (vchess.vh domain):
  - BB_W=64;
  - popcount core latency constant (5), used as the CORE_LAT default;
  - full-board constant 64'hFFFF_FFFF_FFFF_FFFF.
- Sub-modules:
  - Instantiate the existing popcount core unchanged.
  - Optional sub-module rr_arbiter (NREQ, req→one-hot grant, pointer update), reusable by other shared engines.

Test Plan:
- Single-word job: req0 sends 64'h00FF_0000_0000_0001, last=1 → resp_valid[0] 6 clocks after handshake, resp_count=9, resp_sat=0.
- All-ones word: req1 sends 64'hFFFF_FFFF_FFFF_FFFF, last=1 → resp_count=64 (not 0).
- Multi-word job:
  - Stimulus: req2 sends 4 words, counts 8, 64, 0, 1, last on the 4th.
  - Required: exactly one response, resp_count=73; no pulse on earlier words.
- Contention:
  - Stimulus: all 4 requesters hold valid continuously with single-word jobs.
  - Required: grants rotate 0,1,2,3,0…; each resp carries the correct tag; 1 word/clock throughput.
- Saturation: req3 sends 40 all-ones words then last → resp_count=2047, resp_sat=1. The next job from req3 starts from 0 and has resp_sat=0.
- Reset mid-job:
  - Stimulus: assert reset (0) with 3 words in flight, then release.
  - Required: no resp_valid; busy=0; a new single-word job of 64'h3 returns 2.
